// File: rtl/addsub_nibble_seq.sv
// Serial add/subtract controller: runs one 4-bit add/sub slice over NIBBLES nibbles,
// least-significant nibble first, and reports the W-bit result with co/ov/zf/nf flags.
`timescale 1ns/1ps
module addsub_nibble_seq #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sub,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] s,
    output logic                 co,
    output logic                 ov,
    output logic                 zf,
    output logic                 nf
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_sub;
    logic          r_carry;
    logic [W-1:0]  r_partial;
    logic [W-1:0]  r_s;
    logic          r_co;
    logic          r_ov;
    logic          r_zf;
    logic          r_nf;

    logic [3:0]    w_a4;
    logic [3:0]    w_b4;
    logic          w_cin;
    logic [3:0]    w_lo4;
    logic [4:0]    w_sum5;
    logic          w_last;
    logic [W-1:0]  w_partial_nx;

    // Single 4-bit slice on the current nibble; cin is sub for nibble 0, else the stored carry.
    always_comb begin
        w_a4   = r_a[4*r_cnt +: 4];
        w_b4   = r_b[4*r_cnt +: 4] ^ {4{r_sub}};
        w_cin  = (r_cnt == '0) ? r_sub : r_carry;
        // Bit 3 of the low-3-bit sum is the carry into the nibble MSB (sign carry-in on top nibble).
        w_lo4  = {1'b0, w_a4[2:0]} + {1'b0, w_b4[2:0]} + {3'b000, w_cin};
        w_sum5 = {1'b0, w_a4} + {1'b0, w_b4} + {4'b0000, w_cin};
        w_last = (r_cnt == CW'(NIBBLES - 1));
        w_partial_nx = r_partial;
        w_partial_nx[4*r_cnt +: 4] = w_sum5[3:0];
    end

    // Control FSM, operand latch, nibble processing and result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_sub     <= 1'b0;
            r_carry   <= 1'b0;
            r_partial <= '0;
            r_s       <= '0;
            r_co      <= 1'b0;
            r_ov      <= 1'b0;
            r_zf      <= 1'b1;
            r_nf      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sub   <= sub;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_partial <= w_partial_nx;
                    r_carry   <= w_sum5[4];
                    r_cnt     <= r_cnt + 1'b1;
                    if (w_last) begin
                        // Final nibble: publish result; flags come straight from this edge's slice.
                        r_cnt   <= '0;
                        r_state <= ST_DONE;
                        r_s     <= w_partial_nx;
                        r_co    <= w_sum5[4] ^ r_sub;
                        r_ov    <= w_lo4[3] ^ w_sum5[4];
                        r_zf    <= (w_partial_nx == '0);
                        r_nf    <= w_partial_nx[W-1];
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake and result outputs.
    always_comb begin
        busy = (r_state != ST_IDLE);
        done = (r_state == ST_DONE);
        s    = r_s;
        co   = r_co;
        ov   = r_ov;
        zf   = r_zf;
        nf   = r_nf;
    end

endmodule

// File: tb/tb_addsub_nibble_seq.sv
// Self-checking bench for addsub_nibble_seq (NIBBLES=4): directed cases, handshake,
// asynchronous reset mid-operation, and randomized operations against a word-level model.
`timescale 1ns/1ps
module tb_addsub_nibble_seq;

    localparam int unsigned NIB = 4;
    localparam int unsigned W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         zf;
    logic         nf;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] last_s;

    addsub_nibble_seq #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co),
        .ov    (ov),
        .zf    (zf),
        .nf    (nf)
    );

    always #5 clk = ~clk;

    // Word-level reference: plain integer arithmetic on the full operands.
    task automatic ref_model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                             output logic [W-1:0] es, output logic eco, output logic eov,
                             output logic ezf, output logic enf);
        int ua, ub, sa, sb, ur, sr;
        ua = int'(ia);
        ub = int'(ib);
        sa = int'($signed(ia));
        sb = int'($signed(ib));
        ur = isub ? (ua - ub) : (ua + ub);
        sr = isub ? (sa - sb) : (sa + sb);
        es  = W'(ur);
        eco = isub ? (ua < ub) : (ur > 65535);
        eov = (sr > 32767) || (sr < -32768);
        ezf = (es == '0);
        enf = es[W-1];
    endtask

    // Issue one operation from IDLE and wait (bounded) for done; reports what was seen.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                         output logic [W-1:0] gs, output logic [3:0] gflags, output int lat,
                         output bit early, output bit tout);
        @(negedge clk);
        a = ia; b = ib; sub = isub; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1; early = 1'b0; tout = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                tout = 1'b0;
                lat  = k;
                break;
            end
            if (s !== last_s || busy !== 1'b1) early = 1'b1;
        end
        gs     = s;
        gflags = {co, ov, zf, nf};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        #12;
        n_checks++;
        if ({busy, done, co, ov, zf, nf} !== 6'b000010) begin
            n_fail++;
            $display("FAIL reset_flags: got busy/done/co/ov/zf/nf=%b, need 000010",
                     {busy, done, co, ov, zf, nf});
        end
        n_checks++;
        if (s !== '0) begin
            n_fail++;
            $display("FAIL reset_s: got %h, need 0000", s);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_s = '0;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] es;
        logic [3:0]   ef;   // {co, ov, zf, nf}
    } dir_t;

    task automatic test_directed();
        dir_t tbl[5];
        logic [W-1:0] gs;
        logic [3:0] gf;
        int lat;
        bit early, tout;
        tbl[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 4'b0000};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b1010};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0101};
        tbl[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 4'b1001};
        tbl[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b0100};
        for (int i = 0; i < 5; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].sub, gs, gf, lat, early, tout);
            n_checks++;
            if (tout || lat != NIB) begin
                n_fail++;
                $display("FAIL dir%0d_latency: got %0d (timeout=%0b), need %0d", i, lat, tout, NIB);
            end
            n_checks++;
            if (early) begin
                n_fail++;
                $display("FAIL dir%0d_hold: s changed or busy low during RUN, need steady", i);
            end
            n_checks++;
            if (gs !== tbl[i].es) begin
                n_fail++;
                $display("FAIL dir%0d_s: got %h, need %h", i, gs, tbl[i].es);
            end
            n_checks++;
            if (gf !== tbl[i].ef) begin
                n_fail++;
                $display("FAIL dir%0d_flags: got co/ov/zf/nf=%b, need %b", i, gf, tbl[i].ef);
            end
            last_s = tbl[i].es;
        end
    endtask

    task automatic test_change_mid_run();
        bit seen;
        @(negedge clk);
        a = 16'h1234; b = 16'h0FCD; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            a = W'($urandom); b = W'($urandom); sub = ~sub;
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen || s !== 16'h2201 || {co, ov, zf, nf} !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_run_inputs: got s=%h flags=%b done_seen=%0b, need 2201 0000",
                     s, {co, ov, zf, nf}, seen);
        end
        last_s = 16'h2201;
    endtask

    task automatic test_hold_start();
        bit prev_done;
        int last_idx, pulses;
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; sub = 1'b0; start = 1'b1;
        prev_done = 1'b0; last_idx = -1; pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                n_checks++;
                if (prev_done) begin
                    n_fail++;
                    $display("FAIL hold_pulse: done high two cycles in a row at %0d, need 1", i);
                end
                n_checks++;
                if (s !== 16'h0002) begin
                    n_fail++;
                    $display("FAIL hold_s: got %h, need 0002", s);
                end
                if (last_idx >= 0) begin
                    n_checks++;
                    if (i - last_idx != NIB + 2) begin
                        n_fail++;
                        $display("FAIL hold_period: got %0d, need %0d", i - last_idx, NIB + 2);
                    end
                end
                last_idx = i;
            end
            prev_done = done;
        end
        start = 1'b0;
        n_checks++;
        if (pulses < 6) begin
            n_fail++;
            $display("FAIL hold_count: got %0d done pulses, need at least 6", pulses);
        end
        repeat (8) @(negedge clk);
        last_s = 16'h0002;
    endtask

    task automatic test_reset_mid_run();
        bit bad;
        logic [W-1:0] gs;
        logic [3:0] gf;
        int lat;
        bit early, tout;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, co, ov, zf, nf} !== 6'b000010 || s !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got busy/done/co/ov/zf/nf=%b s=%h, need 000010 0000",
                     {busy, done, co, ov, zf, nf}, s);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_abort: got busy/done activity after reset, need idle");
        end
        last_s = '0;
        do_op(16'h0003, 16'h0003, 1'b1, gs, gf, lat, early, tout);
        n_checks++;
        if (tout || gs !== '0 || gf !== 4'b0010) begin
            n_fail++;
            $display("FAIL post_reset_sub: got s=%h flags=%b timeout=%0b, need 0000 0010",
                     gs, gf, tout);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ra, rb, es, gs;
        logic rsub, eco, eov, ezf, enf;
        logic [3:0] gf;
        int lat;
        bit early, tout;
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 7))
                0: ra = 16'hFFFF;
                1: rb = 16'h8000;
                2: rb = ra;
                default: ;
            endcase
            rsub = 1'($urandom);
            ref_model(ra, rb, rsub, es, eco, eov, ezf, enf);
            do_op(ra, rb, rsub, gs, gf, lat, early, tout);
            n_checks++;
            if (tout || lat != NIB || early) begin
                n_fail++;
                $display("FAIL rnd%0d_timing: lat=%0d timeout=%0b early=%0b, need lat %0d",
                         i, lat, tout, early, NIB);
            end
            n_checks++;
            if (gs !== es || gf !== {eco, eov, ezf, enf}) begin
                n_fail++;
                $display("FAIL rnd%0d_result: %h %s %h got s=%h flags=%b, need s=%h flags=%b",
                         i, ra, rsub ? "-" : "+", rb, gs, gf, es, {eco, eov, ezf, enf});
            end
            last_s = es;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_change_mid_run();
        test_hold_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
